uart_rx_core: RTL and testbench

UART receive stage that consumes the 16x oversample enable produced by the baud clock generator. It:
- synchronises the serial input;
- finds and qualifies start bits;
- samples data, parity and stop bits at mid-bit;
- presents each completed character on a holding register with a full/read handshake toward the APB register block.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_core.sv | 146 ++++++++++++++
 tb/tb_uart_rx_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversample tick positions and the
// parity helper also used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] TICK_LAST  = 4'd15;

  // Parity bit a transmitter would send for this character (bit 7 ignored in 7-bit mode).
  function automatic logic parity_calc(input logic [7:0] data, input logic bit8,
                                       input logic odd_n_even);
    logic [7:0] masked;
    masked = bit8 ? data : {1'b0, data[6:0]};
    return (^masked) ^ odd_n_even;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the asynchronous serial line; every stage resets to 1
// so a reset never looks like a start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync_reg [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) sync_reg[0] <= 1'b1;
    else       sync_reg[0] <= d;
  end

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) sync_reg[gi] <= 1'b1;
        else       sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver driven by a 16x oversample enable, with a full/read holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting on ticks 7/8/9 instead of a single tick-8 sample.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       receive_full,
  output logic       parity_err,
  output logic       overflow,
  output logic       framing_err,
  output logic       rx_idle
);

  logic       rx_s;
  rx_state_t  state_reg;
  logic [3:0] cnt_reg;
  logic [2:0] bit_idx_reg;
  logic [7:0] shift_reg;
  logic       par_err_reg;
  logic       s_mid_reg;
  logic       bit_val;
  logic       tick_dec;
  logic       tick_last;
  logic       last_bit;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic s_lo_reg;

  always_ff @(posedge clk) begin
    if (reset)                                     s_lo_reg <= 1'b1;
    else if (baud_clock && cnt_reg == SAMPLE_LO)   s_lo_reg <= rx_s;
  end

  // The tick-9 sample is taken live, so the vote resolves on the decision tick itself.
  assign bit_val = (s_lo_reg & s_mid_reg) | (s_lo_reg & rx_s) | (s_mid_reg & rx_s);
`else
  assign bit_val = s_mid_reg;
`endif

  assign tick_dec  = baud_clock && (cnt_reg == SAMPLE_HI);
  assign tick_last = baud_clock && (cnt_reg == TICK_LAST);
  assign last_bit  = (bit_idx_reg == (bit8 ? 3'd7 : 3'd6));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      par_err_reg  <= 1'b0;
      s_mid_reg    <= 1'b1;
      rx_byte      <= 8'h00;
      receive_full <= 1'b0;
      parity_err   <= 1'b0;
      overflow     <= 1'b0;
      framing_err  <= 1'b0;
      rx_idle      <= 1'b1;
    end else begin
      overflow    <= 1'b0;
      framing_err <= 1'b0;

      if (baud_clock) begin
        cnt_reg <= cnt_reg + 4'd1;
        if (cnt_reg == SAMPLE_MID) s_mid_reg <= rx_s;
      end

      // A completion in the same cycle overrides this clear below.
      if (read_rx_byte) begin
        receive_full <= 1'b0;
        parity_err   <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg <= 4'd0;
          if (baud_clock && !rx_s) begin
            cnt_reg     <= 4'd1;
            state_reg   <= START;
            rx_idle     <= 1'b0;
            shift_reg   <= 8'h00;
            par_err_reg <= 1'b0;
          end
        end
        START: begin
          if (tick_dec && bit_val) begin
            state_reg <= IDLE;
            rx_idle   <= 1'b1;
            cnt_reg   <= 4'd0;
          end else if (tick_last) begin
            state_reg   <= DATA;
            bit_idx_reg <= 3'd0;
          end
        end
        DATA: begin
          if (tick_dec) shift_reg[bit_idx_reg] <= bit_val;
          if (tick_last) begin
            if (last_bit) state_reg <= parity_en ? PARITY : STOP;
            else          bit_idx_reg <= bit_idx_reg + 3'd1;
          end
        end
        PARITY: begin
          if (tick_dec) par_err_reg <= (parity_calc(shift_reg, bit8, odd_n_even) != bit_val);
          if (tick_last) state_reg <= STOP;
        end
        STOP: begin
          if (tick_dec) begin
            state_reg <= IDLE;
            rx_idle   <= 1'b1;
            cnt_reg   <= 4'd0;
            if (!receive_full || read_rx_byte) begin
              rx_byte      <= shift_reg;
              parity_err   <= par_err_reg;
              receive_full <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
            if (!bit_val) framing_err <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          rx_idle   <= 1'b1;
          cnt_reg   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: tick-aligned frames with hand-computed results.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_clock = 1'b0;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       read_rx_byte = 1'b0;
  logic [7:0] rx_byte;
  logic       receive_full;
  logic       parity_err;
  logic       overflow;
  logic       framing_err;
  logic       rx_idle;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cycles = 0;
  int fe_cycles  = 0;
  int ovf_snap;
  int fe_snap;

  uart_rx_core #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .baud_clock   (baud_clock),
    .rx           (rx),
    .bit8         (bit8),
    .parity_en    (parity_en),
    .odd_n_even   (odd_n_even),
    .read_rx_byte (read_rx_byte),
    .rx_byte      (rx_byte),
    .receive_full (receive_full),
    .parity_err   (parity_err),
    .overflow     (overflow),
    .framing_err  (framing_err),
    .rx_idle      (rx_idle)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_clock = 1'b1;
      @(negedge clk);
      baud_clock = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (overflow)    ovf_cycles <= ovf_cycles + 1;
    if (framing_err) fe_cycles  <= fe_cycles + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Returns on the falling edge right after the next clk edge that carries a baud tick.
  task automatic wait_tick();
    @(posedge clk);
    while (!baud_clock) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  task automatic do_read();
    @(negedge clk);
    read_rx_byte = 1'b1;
    @(negedge clk);
    read_rx_byte = 1'b0;
  endtask

  // Frame position 0 is the start bit; gpos/gtick invert rx for one tick.
  // Returns just after the stop-bit decision tick (stop tick 9).
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                            input logic pbit, input logic stop, input int gpos,
                            input int gtick, input logic rd_at_end);
    logic [10:0] fr;
    int nb;
    fr = '0;
    nb = 1 + nbits + (pen ? 1 : 0);
    fr[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fr[1+i] = data[i];
    if (pen) fr[1+nbits] = pbit;
    for (int p = 0; p < nb; p++) begin
      for (int t = 0; t < 16; t++) begin
        rx = (p == gpos && t == gtick) ? ~fr[p] : fr[p];
        wait_tick();
        if (p == 0 && t == 12) check("busy_mid_frame", {31'd0, rx_idle}, 32'd0);
      end
    end
    rx = stop;
    for (int t = 0; t < 9; t++) wait_tick();
    if (rd_at_end) begin
      do begin
        @(negedge clk);
        #1;
      end while (!baud_clock);
      read_rx_byte = 1'b1;
      @(posedge clk);
      @(negedge clk);
      read_rx_byte = 1'b0;
    end else begin
      wait_tick();
    end
    rx = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_byte",      {24'd0, rx_byte},     32'h00);
    check("rst_receive_full", {31'd0, receive_full}, 32'd0);
    check("rst_parity_err",   {31'd0, parity_err},  32'd0);
    check("rst_overflow",     {31'd0, overflow},    32'd0);
    check("rst_framing_err",  {31'd0, framing_err}, 32'd0);
    check("rst_rx_idle",      {31'd0, rx_idle},     32'd1);
    reset = 1'b0;
    idle_ticks(4);

    // 8N1 0xA5
    ovf_snap = ovf_cycles; fe_snap = fe_cycles;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
    check("a5_rx_byte",      {24'd0, rx_byte},      32'hA5);
    check("a5_receive_full", {31'd0, receive_full}, 32'd1);
    check("a5_parity_err",   {31'd0, parity_err},   32'd0);
    check("a5_rx_idle",      {31'd0, rx_idle},      32'd1);
    idle_ticks(3);
    check("a5_no_ovf", ovf_cycles - ovf_snap, 32'd0);
    check("a5_no_fe",  fe_cycles - fe_snap,   32'd0);
    do_read();
    check("a5_read_clears_full", {31'd0, receive_full}, 32'd0);
    check("a5_read_keeps_byte",  {24'd0, rx_byte},      32'hA5);

    // 7E1 0x35 with wrong parity bit 1 (four ones -> even parity bit is 0)
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    idle_ticks(2);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
    check("7e1_rx_byte",    {24'd0, rx_byte},    32'h35);
    check("7e1_parity_err", {31'd0, parity_err}, 32'd1);
    idle_ticks(2);
    do_read();
    check("7e1_read_clears_perr", {31'd0, parity_err}, 32'd0);

    // 7O1 0x35 with correct odd parity bit 1
    odd_n_even = 1'b1;
    idle_ticks(2);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
    check("7o1_parity_ok", {31'd0, parity_err}, 32'd0);
    check("7o1_full",      {31'd0, receive_full}, 32'd1);
    idle_ticks(2);
    do_read();

    // 3-tick low glitch is a false start
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    idle_ticks(2);
    ovf_snap = ovf_cycles; fe_snap = fe_cycles;
    rx = 1'b0;
    repeat (3) wait_tick();
    idle_ticks(20);
    check("glitch_idle",  {31'd0, rx_idle},      32'd1);
    check("glitch_full",  {31'd0, receive_full}, 32'd0);
    check("glitch_no_ovf", ovf_cycles - ovf_snap, 32'd0);
    check("glitch_no_fe",  fe_cycles - fe_snap,   32'd0);

    // Overflow: 0x11 then 0x22 without a read
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
    idle_ticks(2);
    ovf_snap = ovf_cycles;
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
    check("ovf_pulse",     {31'd0, overflow},     32'd1);
    check("ovf_keeps_old", {24'd0, rx_byte},      32'h11);
    check("ovf_full",      {31'd0, receive_full}, 32'd1);
    idle_ticks(2);
    check("ovf_one_cycle", ovf_cycles - ovf_snap, 32'd1);
    do_read();

    // Read coinciding with the second completion
    idle_ticks(2);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
    idle_ticks(2);
    ovf_snap = ovf_cycles;
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1);
    check("rdcoin_rx_byte", {24'd0, rx_byte},      32'h22);
    check("rdcoin_full",    {31'd0, receive_full}, 32'd1);
    idle_ticks(2);
    check("rdcoin_no_ovf",  ovf_cycles - ovf_snap, 32'd0);
    do_read();

    // Framing error on 0x5A
    idle_ticks(2);
    fe_snap = fe_cycles;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0);
    check("fe_pulse",   {31'd0, framing_err},  32'd1);
    check("fe_rx_byte", {24'd0, rx_byte},      32'h5A);
    check("fe_full",    {31'd0, receive_full}, 32'd1);
    idle_ticks(3);
    check("fe_one_cycle", fe_cycles - fe_snap, 32'd1);
    do_read();

    // Wrong level on tick 8 of data bit 3 of 0x00
    idle_ticks(2);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 4, 8, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    check("vote_rx_byte", {24'd0, rx_byte}, 32'h00);
`else
    check("vote_rx_byte", {24'd0, rx_byte}, 32'h08);
`endif
    idle_ticks(2);
    do_read();

    // Reset in the middle of a frame abandons it
    idle_ticks(2);
    rx = 1'b0;
    repeat (20) wait_tick();
    check("midrst_busy", {31'd0, rx_idle}, 32'd0);
    rx = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_idle", {31'd0, rx_idle}, 32'd1);
    idle_ticks(200);
    check("midrst_no_char", {31'd0, receive_full}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
